// File: rtl/exp_pkg.sv
// Shared types and elaboration-time helpers for the Taylor-series exp engine.
package exp_pkg;

  // Controller states: one multiply by x, one multiply by 1/k, one accumulate per term.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULX = 3'd1,
    MULC = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Reciprocal coefficient floor(2^frac / k) in the same fixed-point format as the data.
  // Index 0 is never used by the series; it returns 0 to keep the table total.
  function automatic int unsigned coef(input int unsigned k, input int unsigned frac);
    int unsigned c;
    if (k == 32'd0) begin
      c = 32'd0;
    end else begin
      c = (32'd1 << frac) / k;
    end
    return c;
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Unsigned fixed-point multiply (a*b >> FRAC) with saturation to all-ones.
module fx_mul_sat #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         sat
);

  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] shifted_s;

  assign prod_s    = (2*W)'(a) * (2*W)'(b);
  assign shifted_s = prod_s >> FRAC;

  // Anything above the kept window means the value does not fit: clamp and flag it.
  always_comb begin
    sat = |shifted_s[2*W-1:W];
    if (sat) begin
      y = {W{1'b1}};
    end else begin
      y = shifted_s[W-1:0];
    end
  end

endmodule

// File: rtl/taylor_exp_engine.sv
// Fixed-point e^x / e^-x engine: truncated Taylor series with its own controller,
// reciprocal table, shared saturating multiplier and clamping accumulator.
module taylor_exp_engine
  import exp_pkg::*;
#(
  parameter int W       = 16,
  parameter int FRAC    = 8,
  parameter int N_TERMS = 8,
  parameter int TH_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               x,
  input  logic                       neg,
  input  logic [TH_W-1:0]            thresh,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               result,
  output logic [$clog2(N_TERMS)-1:0] terms_used,
  output logic                       overflow
);

  localparam int         K_W    = $clog2(N_TERMS);
  localparam logic [W-1:0]   ONE    = W'(1) << FRAC;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_TERMS - 1);

  state_t state_r;
  state_t state_nxt_s;

  logic [W-1:0]    x_r;
  logic            neg_r;
  logic [TH_W-1:0] thresh_r;
  logic [W-1:0]    term_r;
  logic [W-1:0]    ans_r;
  logic [K_W-1:0]  k_r;
  logic            ovf_r;

  logic [W-1:0]    result_r;
  logic [K_W-1:0]  terms_used_r;
  logic            overflow_r;
  logic            out_valid_r;
  logic            in_ready_r;

  logic [W-1:0]    coef_s [0:N_TERMS-1];
  logic [W-1:0]    mul_b_s;
  logic [W-1:0]    mul_y_s;
  logic            mul_sat_s;

  logic [W:0]      sum_s;
  logic [W:0]      diff_s;
  logic            sub_s;
  logic            carry_s;
  logic [W-1:0]    ans_nxt_s;
  logic            stop_s;
  logic            accept_s;

  // Reciprocal table is fixed at elaboration.
  for (genvar i = 0; i < N_TERMS; i++) begin : g_coef
    assign coef_s[i] = W'(coef(i, FRAC));
  end

  assign accept_s = in_valid & in_ready_r;

  // Shared multiplier operand: the captured x in MULX, the 1/k coefficient otherwise.
  always_comb begin
    if (state_r == MULC) begin
      mul_b_s = coef_s[k_r];
    end else begin
      mul_b_s = x_r;
    end
  end

  fx_mul_sat #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mul (
    .a   (term_r),
    .b   (mul_b_s),
    .y   (mul_y_s),
    .sat (mul_sat_s)
  );

  assign sum_s  = {1'b0, ans_r} + {1'b0, term_r};
  assign diff_s = {1'b0, ans_r} - {1'b0, term_r};
  assign sub_s  = neg_r & k_r[0];

  // Accumulator update with clamp: carry saturates high and flags, borrow clamps to zero quietly.
  always_comb begin
    carry_s   = 1'b0;
    ans_nxt_s = ans_r;
    if (sub_s) begin
      if (diff_s[W]) begin
        ans_nxt_s = {W{1'b0}};
      end else begin
        ans_nxt_s = diff_s[W-1:0];
      end
    end else begin
      carry_s = sum_s[W];
      if (sum_s[W]) begin
        ans_nxt_s = {W{1'b1}};
      end else begin
        ans_nxt_s = sum_s[W-1:0];
      end
    end
    stop_s = (term_r < W'(thresh_r)) | (k_r == K_LAST) | ovf_r | carry_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: three cycles per term, then hold the result until it is taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = MULX;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MULX: state_nxt_s = MULC;
      MULC: state_nxt_s = ACC;
      ACC: begin
        if (stop_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MULX;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output registers; a term that has saturated stays pinned at all-ones
  // because its scaled-down successors would no longer mean anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r          <= {W{1'b0}};
      neg_r        <= 1'b0;
      thresh_r     <= {TH_W{1'b0}};
      term_r       <= {W{1'b0}};
      ans_r        <= {W{1'b0}};
      k_r          <= {K_W{1'b0}};
      ovf_r        <= 1'b0;
      result_r     <= {W{1'b0}};
      terms_used_r <= {K_W{1'b0}};
      overflow_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      in_ready_r <= (state_nxt_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r      <= x;
            neg_r    <= neg;
            thresh_r <= thresh;
            term_r   <= ONE;
            ans_r    <= ONE;
            k_r      <= K_W'(1);
            ovf_r    <= 1'b0;
          end
        end
        MULX, MULC: begin
          term_r <= (ovf_r | mul_sat_s) ? {W{1'b1}} : mul_y_s;
          ovf_r  <= ovf_r | mul_sat_s;
        end
        ACC: begin
          ans_r <= ans_nxt_s;
          ovf_r <= ovf_r | carry_s;
          if (stop_s) begin
            result_r     <= ans_nxt_s;
            terms_used_r <= k_r;
            overflow_r   <= ovf_r | carry_s;
            out_valid_r  <= 1'b1;
          end else begin
            k_r <= k_r + K_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign terms_used = terms_used_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_taylor_exp_engine.sv
// Self-checking bench for taylor_exp_engine: directed cases plus randomized
// operands checked against a plain-arithmetic series model.
module tb_taylor_exp_engine;

  localparam int N_TERMS = 8;
  localparam int FRAC    = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        neg;
  logic [7:0]  thresh;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  terms_used;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  taylor_exp_engine #(
    .W       (16),
    .FRAC    (FRAC),
    .N_TERMS (N_TERMS),
    .TH_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .neg        (neg),
    .thresh     (thresh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .terms_used (terms_used),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Series e^x / e^-x from the rules: term *= x, term *= floor(1/k), add or subtract.
  function automatic void model(input int unsigned xi, input bit ni, input int unsigned ti,
                                output int unsigned res, output int unsigned tu,
                                output int unsigned ov);
    longint unsigned term;
    longint unsigned ans;
    longint unsigned t;
    bit o;
    bit done;
    term = 64'd256;
    ans  = 64'd256;
    o    = 1'b0;
    done = 1'b0;
    res  = 0;
    tu   = 0;
    for (int k = 1; k < N_TERMS; k++) begin
      if (!done) begin
        t = (term * longint'(xi)) >> FRAC;
        if (t > 64'd65535) o = 1'b1;
        term = o ? 64'd65535 : t;
        t = (term * ((64'd1 << FRAC) / longint'(k))) >> FRAC;
        if (t > 64'd65535) o = 1'b1;
        term = o ? 64'd65535 : t;
        if (ni && (k % 2 == 1)) begin
          ans = (ans >= term) ? ans - term : 64'd0;
        end else begin
          ans = ans + term;
          if (ans > 64'd65535) begin
            ans = 64'd65535;
            o   = 1'b1;
          end
        end
        if (term < longint'(ti) || k == N_TERMS - 1 || o) begin
          res  = int'(ans);
          tu   = k;
          done = 1'b1;
        end
      end
    end
    ov = o;
  endfunction

  task automatic start_op(input logic [15:0] xi, input logic ni, input logic [7:0] ti);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", 32'(in_ready), 32'd1);
    x        = xi;
    neg      = ni;
    thresh   = ti;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] xi, input logic ni,
                        input logic [7:0] ti, input logic [15:0] er,
                        input logic [2:0] et, input logic eo);
    int lat;
    start_op(xi, ni, ti);
    chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(int'(et) * 3));
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_terms"}, 32'(terms_used), 32'(et));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int unsigned mr, mt, mo;
    logic [15:0] rx;
    logic        rn;
    logic [7:0]  rt;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 16'h0000;
    neg       = 1'b0;
    thresh    = 8'h00;
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_terms", 32'(terms_used), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", 32'(in_ready), 32'd1);

    run_op("c1_exp1", 16'h0100, 1'b0, 8'd0, 16'h02B5, 3'd7, 1'b0);
    run_op("c2_expm1", 16'h0100, 1'b1, 8'd0, 16'h005F, 3'd7, 1'b0);
    run_op("c3_zero", 16'h0000, 1'b0, 8'd1, 16'h0100, 3'd1, 1'b0);
    run_op("c4_sat", 16'h0800, 1'b0, 8'd0, 16'hFFFF, 3'd3, 1'b1);

    // Backpressure: result held, busy, stray in_valid pulses ignored.
    out_ready = 1'b0;
    start_op(16'h0100, 1'b0, 8'd0);
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'd21);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      x        = 16'h0000;
      thresh   = 8'd1;
      @(posedge clk);
      #1;
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_result_hold", 32'(result), 32'h02B5);
      chk("bp_busy_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_result_kept", 32'(result), 32'h02B5);
    chk("bp_terms_kept", 32'(terms_used), 32'd7);

    // Reset during MULC of case 1 aborts silently; a fresh run then completes.
    start_op(16'h0100, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_terms", 32'(terms_used), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_no_partial", 32'(out_valid), 32'd0);
    run_op("c6_after_rst", 16'h0000, 1'b0, 8'd1, 16'h0100, 3'd1, 1'b0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx = 16'($urandom_range(0, 65535));
      end else begin
        rx = 16'($urandom_range(0, 1024));
      end
      rn = 1'($urandom_range(0, 1));
      rt = 8'($urandom_range(0, 20));
      model(32'(rx), rn, 32'(rt), mr, mt, mo);
      run_op("rand", rx, rn, rt, 16'(mr), 3'(mt), 1'(mo));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
